// File: rtl/uart_rsa_frame_ctrl_if.sv
// Byte-level UART and RSA-core signal bundle seen by the frame controller.
// The master side is the controller; the slave side is the UART and the core.
interface uart_rsa_frame_ctrl_if #(
    parameter int unsigned W = 32
);
    logic         rx_readable;
    logic [7:0]   rx_data;
    logic         rx_used_tick;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy;
    logic [W-1:0] exp_out;
    logic [W-1:0] mod_out;
    logic [W-1:0] msg_out;
    logic         core_start;
    logic         core_done;
    logic [W-1:0] core_result;

    modport master (
        input  rx_readable, rx_data, tx_busy, core_done, core_result,
        output rx_used_tick, tx_start, tx_data, exp_out, mod_out, msg_out, core_start
    );

    modport slave (
        output rx_readable, rx_data, tx_busy, core_done, core_result,
        input  rx_used_tick, tx_start, tx_data, exp_out, mod_out, msg_out, core_start
    );
endinterface

// File: rtl/uart_rsa_frame_ctrl.sv
// Command-frame controller between the UART byte interface and the RSA core:
// loads exponent/modulus/message, runs the core and streams the result back.
module uart_rsa_frame_ctrl #(
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rsa_frame_ctrl_if.master bus,
    output logic                  busy,
    output logic                  frame_err
);
    localparam int unsigned W     = 8 * DATA_BYTES;
    localparam int unsigned CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CMD_EXP  = 8'h10;
    localparam logic [7:0] CMD_MOD  = 8'h11;
    localparam logic [7:0] CMD_MSG  = 8'h12;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_COMMIT,
        S_START,
        S_WAIT,
        S_SEND,
        S_SEND_HOLD,
        S_ERR_TX
    } state_t;

    state_t           state;
    logic [7:0]       cmd_q;
    logic [CNT_W-1:0] byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [W-1:0]     stage;
    logic [W-1:0]     res_q;
    logic             hold_skip;
    logic             err_mode;

    // The UART readable flag lags the consume pulse by a cycle, so skip it then.
    logic rx_take;
    logic last_byte;
    assign rx_take   = bus.rx_readable && !bus.rx_used_tick;
    assign last_byte = (byte_cnt == CNT_W'(DATA_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cmd_q            <= '0;
            byte_cnt         <= '0;
            tmo_cnt          <= '0;
            stage            <= '0;
            res_q            <= '0;
            hold_skip        <= 1'b0;
            err_mode         <= 1'b0;
            busy             <= 1'b0;
            frame_err        <= 1'b0;
            bus.rx_used_tick <= 1'b0;
            bus.tx_start     <= 1'b0;
            bus.tx_data      <= '0;
            bus.core_start   <= 1'b0;
            bus.exp_out      <= '0;
            bus.mod_out      <= '0;
            bus.msg_out      <= '0;
        end else begin
            bus.rx_used_tick <= 1'b0;
            bus.tx_start     <= 1'b0;
            bus.core_start   <= 1'b0;
            frame_err        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_take) begin
                        bus.rx_used_tick <= 1'b1;
                        busy             <= 1'b1;
                        byte_cnt         <= '0;
                        tmo_cnt          <= '0;
                        cmd_q            <= bus.rx_data;
                        if (bus.rx_data inside {CMD_EXP, CMD_MOD, CMD_MSG}) begin
                            state <= S_RECV;
                        end else begin
                            state <= S_ERR_TX;
                        end
                    end
                end

                S_RECV: begin
                    if (rx_take) begin
                        bus.rx_used_tick         <= 1'b1;
                        stage[8*byte_cnt +: 8]   <= bus.rx_data;
                        tmo_cnt                  <= '0;
                        if (last_byte) begin
                            state <= S_COMMIT;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Stalled frame: drop the partial payload, keep the operands.
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        stage     <= '0;
                        tmo_cnt   <= '0;
                        state     <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_COMMIT: begin
                    case (cmd_q)
                        CMD_EXP: begin
                            bus.exp_out <= stage;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end
                        CMD_MOD: begin
                            bus.mod_out <= stage;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end
                        default: begin
                            bus.msg_out    <= stage;
                            bus.core_start <= 1'b1;
                            state          <= S_START;
                        end
                    endcase
                end

                S_START: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.core_done) begin
                        res_q    <= bus.core_result;
                        byte_cnt <= '0;
                        err_mode <= 1'b0;
                        state    <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= res_q[8*byte_cnt +: 8];
                        hold_skip    <= 1'b1;
                        state        <= S_SEND_HOLD;
                    end
                end

                S_SEND_HOLD: begin
                    // First cycle after tx_start the UART has not raised busy yet.
                    if (hold_skip) begin
                        hold_skip <= 1'b0;
                    end else if (!bus.tx_busy) begin
                        if (err_mode || last_byte) begin
                            err_mode <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                            state    <= S_SEND;
                        end
                    end
                end

                S_ERR_TX: begin
                    frame_err <= 1'b1;
                    res_q     <= W'(ERR_BYTE);
                    byte_cnt  <= '0;
                    err_mode  <= 1'b1;
                    state     <= S_SEND;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rsa_frame_ctrl.md
# uart_rsa_frame_ctrl

Byte-level command controller between the `UART_Pong` transceiver and the RSA modular-exponentiation core. Parses command frames arriving on the UART RX byte interface and loads exponent, modulus and message operands. Starts the core, waits for completion, and streams the result back through the UART TX byte interface. This is the only block that drives `rx_used_tick`, `tx_start` and `tx_data` on `UART_Pong` in the RSA top level.

## Interface
- `DATA_BYTES`, 4: operand width in bytes; `W = 8*DATA_BYTES`.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle cycles between bytes inside a frame; minimum legal value 2.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_readable` in 1: UART has an unread byte (level).
- `rx_data` in 8: unread byte, valid while `rx_readable`.
- `rx_used_tick` out 1: one-cycle pulse; consumes the current RX byte.
- `tx_start` out 1: one-cycle pulse; UART transmits `tx_data`.
- `tx_data` out 8: byte to transmit; held stable from `tx_start` until `tx_busy` falls.
- `tx_busy` in 1: UART transmitter busy.
- `exp_out` out W: committed exponent.
- `mod_out` out W: committed modulus.
- `msg_out` out W: committed message.
- `core_start` out 1: one-cycle start pulse to the RSA core.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_result` in W: result, valid in the `core_done` cycle.
- `busy` out 1: high in every state except IDLE.
- `frame_err` out 1: one-cycle pulse on a bad command or a timeout.

## Operation
- Frame format: command byte, then `DATA_BYTES` payload bytes, least-significant byte first.
- Command 0x10 loads the exponent.
- Command 0x11 loads the modulus.
- Command 0x12 loads the message and then runs the core.
- Any other command byte is rejected.
- States:
  - IDLE: wait for a byte. On consume: a valid command goes to RECV with `byte_cnt=0`; an invalid command goes to ERR_TX.
  - RECV: each consumed byte is written into `stage[8*byte_cnt +: 8]` and `byte_cnt` increments. When the last byte is consumed:
    - cmd 0x10 or 0x11: commit `stage` to the target register, then go to IDLE.
    - cmd 0x12: commit `stage` to `msg_out`, then go to START.
  - START: assert `core_start` for one cycle, then go to WAIT.
  - WAIT: on `core_done`, latch `core_result` into the TX shift register and go to SEND with `byte_cnt=0`.
  - SEND: when `tx_busy` is low, pulse `tx_start` with `tx_data = result[8*byte_cnt +: 8]`, then go to SEND_HOLD.
  - SEND_HOLD: ignore `tx_busy` for 1 cycle, then wait for `tx_busy` low. Then increment `byte_cnt`; after `DATA_BYTES` bytes go to IDLE, otherwise go to SEND.
  - ERR_TX: pulse `frame_err`; send byte 0xEE using the same SEND/SEND_HOLD rules; then go to IDLE.
- RX consume rule:
  - Bytes are consumed only in IDLE and RECV.
  - After an `rx_used_tick` pulse, `rx_readable` is ignored for the following cycle, because the UART flag lags by one cycle.
  - Maximum consume rate is one byte per 2 cycles.
- Bytes arriving in START, WAIT, SEND or ERR_TX are left unconsumed in the UART.
- Timeout:
  - A counter in RECV clears on every consume and increments on every other cycle.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_err`, go to IDLE, discard `stage`, and leave the target registers unchanged.
- Aborted frames never modify `exp_out`, `mod_out` or `msg_out`.
- A `core_done` outside WAIT is ignored.

## Timing
- Reset values:
  - State: IDLE.
  - `rx_used_tick`, `tx_start`, `core_start`, `frame_err`, `busy`: 0.
  - `tx_data`: 0x00.
  - `exp_out`, `mod_out`, `msg_out`, `stage`: 0.
  - All counters: 0.
- All outputs are registered.
- `rx_used_tick` is asserted in the cycle after `rx_readable` is sampled high.
- Operand commit: the target register updates in the cycle after the last payload byte's `rx_used_tick`.
- `core_start` is asserted in the cycle after `msg_out` updates, so it coincides with the new `msg_out` value being visible.
- The first `tx_start` occurs at least 1 cycle after `core_done`; it is not asserted while `tx_busy` is high.
- Reset asserted mid-operation: the block returns to IDLE on the next edge and no further pulses are issued. A byte that is partially transmitted by the UART is not the controller's concern.

## Test plan
- Load sequence, `DATA_BYTES=4`:
  - Send 0x10,01,00,01,00 → `exp_out=0x00010001`.
  - Send 0x11,0B,00,00,00 → `mod_out=0x0000000B`.
  - `core_start` stays 0 throughout.
- Run:
  - Send 0x12,04,00,00,00 → `msg_out=0x4`; `core_start` pulses once.
  - Bench core returns `core_done` with result 0x12345678 → TX bytes 78,56,34,12 in order.
  - `busy` goes low after the last byte.
- Bad command: byte 0x55 → `frame_err` pulses once; TX sends 0xEE; registers unchanged; next valid frame is accepted normally.
- Timeout (`TIMEOUT_CYCLES=50`):
  - Send 0x11,AA,BB, then stall for 50 cycles → `frame_err` pulses; `mod_out` is unchanged.
  - Next frame 0x11,01,02,03,04 → `mod_out=0x04030201`.
- Back-pressure:
  - Hold `tx_busy` high for 200 cycles after each `tx_start` → exactly one `tx_start` per byte.
  - `tx_data` is stable throughout each busy period.
  - RX bytes sent during SEND remain unconsumed (`rx_used_tick` stays 0).
- Reset mid-RECV (after 2 payload bytes) → all outputs return to their reset values.
  - The following full frame loads correctly with no stale partial data.
